// File: rtl/gnt_fifo.sv
// gnt_fifo: two-client grant-driven FIFO. Each client raises valid, the FIFO
// forwards it as a request to an external arbiter, and a granted word is
// written with its source id. The head is presented on out_* and popped with
// out_ready.
//
// Ports:
//   clock, reset        - rising-edge clock, async active-low reset
//   valid_x, data_x     - client x word pending / payload (x = 0,1)
//   req_x               - request to the arbiter for client x
//   gnt_x               - arbiter grant for client x
//   ready_x             - client x word accepted this cycle
//   out_valid/data/src  - FIFO head valid, payload, source client
//   out_ready           - consumer pops head when out_valid is high
//   count               - current occupancy
//   gnt_err             - sticky: both grants seen in one cycle
module gnt_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       valid_0,
    input  logic [DATA_W-1:0]          data_0,
    input  logic                       valid_1,
    input  logic [DATA_W-1:0]          data_1,
    output logic                       req_0,
    output logic                       req_1,
    input  logic                       gnt_0,
    input  logic                       gnt_1,
    output logic                       ready_0,
    output logic                       ready_1,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_src,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       gnt_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W:0] mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            full;
    logic            empty;
    logic            both;
    logic            push_0;
    logic            push_1;
    logic            push;
    logic            pop;
    logic [DATA_W:0] wdata;
    logic [DATA_W:0] head;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign both  = gnt_0 & gnt_1;

    assign req_0 = valid_0 & ~full;
    assign req_1 = valid_1 & ~full;

    // A double grant is an arbiter fault: accept neither word.
    assign push_0 = gnt_0 & valid_0 & ~full & ~both;
    assign push_1 = gnt_1 & valid_1 & ~full & ~both;
    assign push   = push_0 | push_1;

    assign ready_0 = push_0;
    assign ready_1 = push_1;

    // Uses the current full, so a pop never frees a slot for a same-cycle push.
    assign pop = ~empty & out_ready;

    // push_0 and push_1 are mutually exclusive.
    assign wdata = push_1 ? {1'b1, data_1} : {1'b0, data_0};

    assign head      = mem[rptr];
    assign out_valid = ~empty;
    assign out_data  = head[DATA_W-1:0];
    assign out_src   = head[DATA_W];

    // Storage is not reset; the pointers and count define what is live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            gnt_err <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (both) begin
                gnt_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gnt_fifo.sv
// tb_gnt_fifo: directed self-checking bench for gnt_fifo.
// One task per scenario, each with its own inline comparisons.
module tb_gnt_fifo;

    logic       clock;
    logic       reset;
    logic       valid_0;
    logic [7:0] data_0;
    logic       valid_1;
    logic [7:0] data_1;
    logic       req_0;
    logic       req_1;
    logic       gnt_0;
    logic       gnt_1;
    logic       ready_0;
    logic       ready_1;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src;
    logic       out_ready;
    logic [2:0] count;
    logic       gnt_err;

    int errors = 0;
    int checks = 0;

    gnt_fifo #(.DATA_W(8), .DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .valid_0   (valid_0),
        .data_0    (data_0),
        .valid_1   (valid_1),
        .data_1    (data_1),
        .req_0     (req_0),
        .req_1     (req_1),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .ready_0   (ready_0),
        .ready_1   (ready_1),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .count     (count),
        .gnt_err   (gnt_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        valid_0 = 1'b0;
        valid_1 = 1'b0;
        gnt_0   = 1'b0;
        gnt_1   = 1'b0;
    endtask

    // One granted push cycle; returns the ready seen for that client.
    task automatic do_push(input bit src, input logic [7:0] d,
                           output logic rdy);
        @(negedge clock);
        if (src) begin
            valid_1 = 1'b1; data_1 = d; gnt_1 = 1'b1;
        end else begin
            valid_0 = 1'b1; data_0 = d; gnt_0 = 1'b1;
        end
        #1 rdy = src ? ready_1 : ready_0;
        @(posedge clock);
        #1 idle_inputs();
    endtask

    // One pop cycle; returns the head seen before the edge.
    task automatic do_pop(output logic v, output logic [7:0] d,
                          output logic s);
        @(negedge clock);
        v = out_valid; d = out_data; s = out_src;
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; out_ready = 1'b0;
        idle_inputs();
        data_0 = '0; data_1 = '0;
        valid_0 = 1'b1;
        @(negedge clock);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d required 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++; if (req_0 !== 1'b1) begin errors++; $display("FAIL rst_req_0: got %b required 1", req_0); end
        checks++; if (req_1 !== 1'b0) begin errors++; $display("FAIL rst_req_1: got %b required 0", req_1); end
        checks++; if (ready_0 !== 1'b0) begin errors++; $display("FAIL rst_ready_0: got %b required 0", ready_0); end
        checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL rst_gnt_err: got %b required 0", gnt_err); end
        valid_0 = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic r, v, s;
        logic [7:0] d;
        do_push(1'b0, 8'hA5, r);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL single_ready: got %b required 1", r); end
        @(negedge clock);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b required 1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h required a5", out_data); end
        checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL single_src: got %b required 0", out_src); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d required 1", count); end
        do_pop(v, d, s);
        @(negedge clock);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_drain: got %0d required 0", count); end
        // Pop request on an empty FIFO must not underflow.
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_pop: got %0d required 0", count); end
    endtask

    task automatic test_fill();
        logic r, v, s;
        logic [7:0] d;
        logic [7:0] ed [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic       es [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            do_push(es[i], ed[i], r);
            checks++; if (r !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b required 1", i, r); end
        end
        @(negedge clock);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d required 4", count); end
        valid_0 = 1'b1; valid_1 = 1'b1; data_0 = 8'h55; data_1 = 8'h66;
        #1;
        checks++; if (req_0 !== 1'b0) begin errors++; $display("FAIL full_req_0: got %b required 0", req_0); end
        checks++; if (req_1 !== 1'b0) begin errors++; $display("FAIL full_req_1: got %b required 0", req_1); end
        gnt_0 = 1'b1;
        #1;
        checks++; if (ready_0 !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", ready_0); end
        @(posedge clock);
        #1 idle_inputs();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_hold: got %0d required 4", count); end
        checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL full_no_err: got %b required 0", gnt_err); end
        for (int i = 0; i < 4; i++) begin
            do_pop(v, d, s);
            checks++; if (v !== 1'b1 || d !== ed[i] || s !== es[i]) begin errors++; $display("FAIL fill_pop%0d: got %b/%h/%b required 1/%h/%b", i, v, d, s, ed[i], es[i]); end
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_empty: got %0d required 0", count); end
    endtask

    task automatic test_full_pop();
        logic r, v, s;
        logic [7:0] d;
        logic [7:0] ed [4] = '{8'hA2, 8'hA3, 8'hA4, 8'hB0};
        for (int i = 0; i < 4; i++) begin
            do_push(1'b0, 8'hA1 + 8'(i), r);
        end
        @(negedge clock);
        out_ready = 1'b1; valid_0 = 1'b1; data_0 = 8'hB0; gnt_0 = 1'b1;
        #1;
        checks++; if (ready_0 !== 1'b0) begin errors++; $display("FAIL fullpop_ready: got %b required 0", ready_0); end
        @(negedge clock);
        out_ready = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count: got %0d required 3", count); end
        #1;
        checks++; if (ready_0 !== 1'b1) begin errors++; $display("FAIL fullpop_retry: got %b required 1", ready_0); end
        @(posedge clock);
        #1 idle_inputs();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_refill: got %0d required 4", count); end
        for (int i = 0; i < 4; i++) begin
            do_pop(v, d, s);
            checks++; if (v !== 1'b1 || d !== ed[i] || s !== 1'b0) begin errors++; $display("FAIL fullpop_pop%0d: got %b/%h/%b required 1/%h/0", i, v, d, s, ed[i]); end
        end
    endtask

    task automatic test_both_gnt();
        logic r, v, s;
        logic [7:0] d;
        do_push(1'b1, 8'hC1, r);
        @(negedge clock);
        valid_0 = 1'b1; valid_1 = 1'b1; data_0 = 8'hC2; data_1 = 8'hC3;
        gnt_0 = 1'b1; gnt_1 = 1'b1;
        #1;
        checks++; if (ready_0 !== 1'b0 || ready_1 !== 1'b0) begin errors++; $display("FAIL both_ready: got %b%b required 00", ready_0, ready_1); end
        @(posedge clock);
        #1 idle_inputs();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL both_count: got %0d required 1", count); end
        checks++; if (gnt_err !== 1'b1) begin errors++; $display("FAIL both_err: got %b required 1", gnt_err); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (gnt_err !== 1'b1) begin errors++; $display("FAIL both_sticky: got %b required 1", gnt_err); end
        do_pop(v, d, s);
        checks++; if (v !== 1'b1 || d !== 8'hC1 || s !== 1'b1) begin errors++; $display("FAIL both_pop: got %b/%h/%b required 1/c1/1", v, d, s); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL both_empty: got %0d required 0", count); end
    endtask

    task automatic test_push_pop();
        logic r, v, s;
        logic [7:0] d;
        do_push(1'b0, 8'hD1, r);
        do_push(1'b1, 8'hD2, r);
        @(negedge clock);
        valid_0 = 1'b1; data_0 = 8'hD3; gnt_0 = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (ready_0 !== 1'b1) begin errors++; $display("FAIL pp_ready: got %b required 1", ready_0); end
        checks++; if (out_data !== 8'hD1) begin errors++; $display("FAIL pp_head: got %h required d1", out_data); end
        @(posedge clock);
        #1 idle_inputs();
        out_ready = 1'b0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL pp_count: got %0d required 2", count); end
        do_pop(v, d, s);
        checks++; if (d !== 8'hD2 || s !== 1'b1) begin errors++; $display("FAIL pp_pop0: got %h/%b required d2/1", d, s); end
        do_pop(v, d, s);
        checks++; if (d !== 8'hD3 || s !== 1'b0) begin errors++; $display("FAIL pp_pop1: got %h/%b required d3/0", d, s); end
    endtask

    task automatic test_async_reset();
        logic r;
        for (int i = 0; i < 3; i++) begin
            do_push(1'(i), 8'hE0 + 8'(i), r);
        end
        @(negedge clock);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL ar_pre: got %0d required 3", count); end
        #2 reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ar_count: got %0d required 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b required 0", out_valid); end
        checks++; if (gnt_err !== 1'b0) begin errors++; $display("FAIL ar_err: got %b required 0", gnt_err); end
        @(negedge clock);
        reset = 1'b1;
        do_push(1'b1, 8'hF1, r);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL ar_first_ready: got %b required 1", r); end
        @(negedge clock);
        checks++; if (count !== 3'd1 || out_data !== 8'hF1 || out_src !== 1'b1) begin errors++; $display("FAIL ar_first: got %0d/%h/%b required 1/f1/1", count, out_data, out_src); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_both_gnt();
        test_push_pop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gnt_fifo.md
GNT_FIFO -- requirements
Module: gnt_fifo

Interface
REQ-001 Parameter DATA_W, default 8, payload width per client.
REQ-002 Parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-003 clock  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous assert, active-low (0 = reset); deassertion synchronous to clock.
REQ-005 valid_0  input  1  client 0 has a word pending; data_0 held stable until accepted.
REQ-006 data_0  input  DATA_W  client 0 payload.
REQ-007 valid_1  input  1  client 1 has a word pending; data_1 held stable until accepted.
REQ-008 data_1  input  DATA_W  client 1 payload.
REQ-009 req_0  output  1  request to the two-client arbiter for client 0.
REQ-010 req_1  output  1  request to the arbiter for client 1.
REQ-011 gnt_0  input  1  arbiter grant for client 0.
REQ-012 gnt_1  input  1  arbiter grant for client 1.
REQ-013 ready_0  output  1  client 0 word accepted this cycle.
REQ-014 ready_1  output  1  client 1 word accepted this cycle.
REQ-015 out_valid  output  1  FIFO head valid.
REQ-016 out_data  output  DATA_W  FIFO head payload.
REQ-017 out_src  output  1  head source client (0 or 1).
REQ-018 out_ready  input  1  downstream consumer pops head when out_valid and out_ready.
REQ-019 count  output  clog2(DEPTH+1)  current occupancy.
REQ-020 gnt_err  output  1  sticky flag: both grants high in one cycle.

Function
REQ-021 full = (count == DEPTH); empty = (count == 0).
REQ-022 req_x = valid_x AND NOT full, combinational, x in {0,1}.
REQ-023 push_x = gnt_x AND valid_x AND NOT full AND NOT (gnt_0 AND gnt_1); ready_x = push_x.
REQ-024 On push_x, write {x, data_x} at write pointer at the rising edge; write pointer increments modulo DEPTH.
REQ-025 Grant with valid_x low, or grant while full: no write, ready_x = 0, no error.
REQ-026 gnt_0 AND gnt_1 in the same cycle: no write, both ready low, gnt_err set at the next edge and held until reset.
REQ-027 out_valid = NOT empty; out_data and out_src are the entry at the read pointer, combinational from storage, with no bypass (minimum push-to-out_valid latency is 1 cycle).
REQ-028 pop = out_valid AND out_ready; read pointer increments modulo DEPTH.
REQ-029 count next = count + push - pop; push and pop in the same cycle leave count unchanged.
REQ-030 When full, a pop in a cycle does not enable a push in that same cycle, because req and ready use the current full.
REQ-031 out_ready while empty has no effect; count never underflows or exceeds DEPTH.
REQ-032 Order out is strictly push order across both clients.

Reset
REQ-033 reset low asynchronously clears both pointers, count = 0, gnt_err = 0; hence out_valid = 0, req_x = valid_x, ready_x = 0 unless granted.
REQ-034 Reset mid-operation discards all stored entries; storage contents need not be cleared.
REQ-035 The first push is possible in the first cycle after reset deasserts.

Verification
REQ-036 Reset then valid_0 = 1, data_0 = 8'hA5, gnt_0 pulse -> ready_0 = 1 that cycle; next cycle out_valid = 1, out_data = A5, out_src = 0, count = 1.
REQ-037 Alternate grants for 4 words (client 1 = 11, client 0 = 22, client 1 = 33, client 0 = 44), out_ready = 0 -> count = 4, req_0 = req_1 = 0, further grant gives ready = 0; then out_ready = 1 -> pops 11/1, 22/0, 33/1, 44/0.
REQ-038 Full plus simultaneous pop and grant -> pop occurs, no push, count = 3; the following cycle push accepted, count = 4.
REQ-039 gnt_0 = gnt_1 = 1 with both valid -> no write, count unchanged, gnt_err = 1 and stays 1 until reset low.
REQ-040 count = 2, push and pop same cycle -> count stays 2, FIFO order preserved.
REQ-041 Assert reset low with count = 3 between clock edges -> count = 0, out_valid = 0 immediately, without waiting for a clock edge.
